// File: rtl/threshold_pkg.sv
// Shared FSM type and compare/count helpers for the threshold requantizer.
package threshold_pkg;

  typedef enum logic {LOAD, RUN} state_t;

  // Helpers take zero/sign-extended operands so one definition serves every width.
  localparam int MAX_VEC = 256;
  localparam int MAX_IN  = 64;

  function automatic int unsigned popcount(input logic [MAX_VEC-1:0] vec, input int width);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < MAX_VEC; i++) begin
      if (i < width) cnt += 32'(vec[i]);
    end
    return cnt;
  endfunction

  function automatic logic cmp_ge(input logic [MAX_IN-1:0] a,
                                  input logic [MAX_IN-1:0] b,
                                  input logic              is_signed);
    if (is_signed) return $signed(a) >= $signed(b);
    return a >= b;
  endfunction

endpackage

// File: rtl/threshold_requant.sv
// Maps each accumulator word to the count of run-time thresholds it meets, plus BIAS,
// through a 2-stage backpressured pipeline; thresholds arrive on their own stream.
module threshold_requant
  import threshold_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 4,
  parameter int IN_SIGNED = 0,
  parameter int BIAS      = 0
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic [IN_WIDTH-1:0]  s_axis_thresh_tdata,
  input  logic                 s_axis_thresh_tvalid,
  output logic                 s_axis_thresh_tready,
  input  logic [IN_WIDTH-1:0]  s_axis_acc_tdata,
  input  logic                 s_axis_acc_tvalid,
  output logic                 s_axis_acc_tready,
  output logic [OUT_WIDTH-1:0] m_axis_out_tdata,
  output logic                 m_axis_out_tvalid,
  input  logic                 m_axis_out_tready,
  input  logic                 cfg_reload,
  output logic                 load_done
);

  localparam int               NUM_THRESH = 2**OUT_WIDTH - 1;
  localparam int               IDX_W      = (NUM_THRESH > 1) ? $clog2(NUM_THRESH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_THRESH - 1);
  localparam logic             IS_SIGNED  = (IN_SIGNED != 0);

  state_t                 state;
  state_t                 state_nxt;
  logic [IDX_W-1:0]       thr_idx;
  logic                   reload_pending;
  logic [IN_WIDTH-1:0]    thr [NUM_THRESH];
  logic                   thresh_fire;
  logic                   acc_fire;
  logic                   adv1;
  logic                   adv2;
  logic                   v1;
  logic                   v2;
  logic [MAX_IN-1:0]      acc_ext;
  logic [NUM_THRESH-1:0]  cmp_vec;
  logic [NUM_THRESH-1:0]  cmp_s1;
  logic [OUT_WIDTH-1:0]   code_nxt;

  function automatic logic [MAX_IN-1:0] extend(input logic [IN_WIDTH-1:0] x);
    logic signed [IN_WIDTH-1:0] xs;
    xs = x;
    if (IS_SIGNED) return MAX_IN'(xs);
    return MAX_IN'(x);
  endfunction

  assign adv2        = !v2 || m_axis_out_tready;
  assign adv1        = !v1 || adv2;
  assign thresh_fire = s_axis_thresh_tvalid && s_axis_thresh_tready;
  assign acc_fire    = s_axis_acc_tvalid && s_axis_acc_tready;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) state <= LOAD;
    else        state <= state_nxt;
  end

  // Reload waits for the pipeline to empty so in-flight words keep the old thresholds.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: if (thresh_fire && thr_idx == LAST_IDX) state_nxt = RUN;
      RUN:  if (reload_pending && !v1 && !v2)       state_nxt = LOAD;
    endcase
  end

  always_comb begin
    s_axis_thresh_tready = 1'b0;
    s_axis_acc_tready    = 1'b0;
    load_done            = 1'b0;
    case (state)
      LOAD: s_axis_thresh_tready = 1'b1;
      RUN: begin
        load_done         = 1'b1;
        s_axis_acc_tready = !reload_pending && adv1;
      end
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      thr_idx        <= '0;
      reload_pending <= 1'b0;
    end else begin
      if (thresh_fire) thr_idx <= (thr_idx == LAST_IDX) ? '0 : thr_idx + IDX_W'(1);
      if (state == RUN && state_nxt == LOAD) reload_pending <= 1'b0;
      else if (state == RUN && cfg_reload)   reload_pending <= 1'b1;
    end
  end

  // The bank holds no reset value; a complete load always precedes RUN.
  always_ff @(posedge ap_clk) begin
    if (thresh_fire) thr[thr_idx] <= s_axis_thresh_tdata;
  end

  assign acc_ext = extend(s_axis_acc_tdata);

  for (genvar i = 0; i < NUM_THRESH; i++) begin : g_cmp
    assign cmp_vec[i] = cmp_ge(acc_ext, extend(thr[i]), IS_SIGNED);
  end

  // Adding in int and truncating gives the wrap modulo 2**OUT_WIDTH for any BIAS sign.
  assign code_nxt = OUT_WIDTH'(int'(popcount(MAX_VEC'(cmp_s1), NUM_THRESH)) + BIAS);

  always_ff @(posedge ap_clk) begin
    if (acc_fire) cmp_s1 <= cmp_vec;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      v1               <= 1'b0;
      v2               <= 1'b0;
      m_axis_out_tdata <= '0;
    end else begin
      if (adv1)       v1               <= acc_fire;
      if (adv2)       v2               <= v1;
      if (adv2 && v1) m_axis_out_tdata <= code_nxt;
    end
  end

  assign m_axis_out_tvalid = v2;

endmodule

// File: tb/tb_threshold_requant.sv
// Directed bench for threshold_requant: three OUT_WIDTH=2 instances share all stimulus
// (unsigned BIAS=0, signed BIAS=0, unsigned BIAS=1) and each output stream is checked.
module tb_threshold_requant;

  localparam int IW = 32;
  localparam int OW = 2;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic [IW-1:0] thresh_tdata;
  logic          thresh_tvalid;
  logic [IW-1:0] acc_tdata;
  logic          acc_tvalid;
  logic          out_tready;
  logic          cfg_reload;

  logic          thresh_rdy_u, thresh_rdy_s, thresh_rdy_b;
  logic          acc_rdy_u, acc_rdy_s, acc_rdy_b;
  logic [OW-1:0] out_data_u, out_data_s, out_data_b;
  logic          out_valid_u, out_valid_s, out_valid_b;
  logic          load_done_u, load_done_s, load_done_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int q_u[$];
  int q_s[$];
  int q_b[$];
  int acc_count = 0;
  int first_acc = -1;
  int first_out = -1;
  int last_out  = -1;

  threshold_requant #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .IN_SIGNED(0), .BIAS(0)) dut_u (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .s_axis_thresh_tdata(thresh_tdata), .s_axis_thresh_tvalid(thresh_tvalid),
    .s_axis_thresh_tready(thresh_rdy_u),
    .s_axis_acc_tdata(acc_tdata), .s_axis_acc_tvalid(acc_tvalid), .s_axis_acc_tready(acc_rdy_u),
    .m_axis_out_tdata(out_data_u), .m_axis_out_tvalid(out_valid_u), .m_axis_out_tready(out_tready),
    .cfg_reload(cfg_reload), .load_done(load_done_u)
  );

  threshold_requant #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .IN_SIGNED(1), .BIAS(0)) dut_s (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .s_axis_thresh_tdata(thresh_tdata), .s_axis_thresh_tvalid(thresh_tvalid),
    .s_axis_thresh_tready(thresh_rdy_s),
    .s_axis_acc_tdata(acc_tdata), .s_axis_acc_tvalid(acc_tvalid), .s_axis_acc_tready(acc_rdy_s),
    .m_axis_out_tdata(out_data_s), .m_axis_out_tvalid(out_valid_s), .m_axis_out_tready(out_tready),
    .cfg_reload(cfg_reload), .load_done(load_done_s)
  );

  threshold_requant #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .IN_SIGNED(0), .BIAS(1)) dut_b (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .s_axis_thresh_tdata(thresh_tdata), .s_axis_thresh_tvalid(thresh_tvalid),
    .s_axis_thresh_tready(thresh_rdy_b),
    .s_axis_acc_tdata(acc_tdata), .s_axis_acc_tvalid(acc_tvalid), .s_axis_acc_tready(acc_rdy_b),
    .m_axis_out_tdata(out_data_b), .m_axis_out_tvalid(out_valid_b), .m_axis_out_tready(out_tready),
    .cfg_reload(cfg_reload), .load_done(load_done_b)
  );

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cyc++;

  // Handshakes are recorded mid-cycle, where the values match what the next edge sees.
  always @(negedge ap_clk) begin
    if (!ap_rst) begin
      if (out_valid_u && out_tready) begin
        q_u.push_back(int'(out_data_u));
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      if (out_valid_s && out_tready) q_s.push_back(int'(out_data_s));
      if (out_valid_b && out_tready) q_b.push_back(int'(out_data_b));
      if (acc_tvalid && acc_rdy_u) begin
        acc_count++;
        if (first_acc < 0) first_acc = cyc;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time expired, required completion before 400000");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic sendThresh(input logic [IW-1:0] value);
    int waited = 0;
    thresh_tvalid = 1'b1;
    thresh_tdata  = value;
    @(negedge ap_clk);
    while (!thresh_rdy_u && waited < 20) begin
      @(negedge ap_clk);
      waited++;
    end
    if (!thresh_rdy_u) checkOutput("thresh_timeout", 0, 1);
    tick();
    thresh_tvalid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [IW-1:0] value, output int stalls);
    stalls     = 0;
    acc_tvalid = 1'b1;
    acc_tdata  = value;
    @(negedge ap_clk);
    while (!acc_rdy_u && stalls < 20) begin
      @(negedge ap_clk);
      stalls++;
    end
    if (!acc_rdy_u) checkOutput("acc_timeout", 0, 1);
    tick();
    acc_tvalid = 1'b0;
  endtask

  task automatic waitOutputs(input int n);
    for (int i = 0; i < 40 && q_u.size() < n; i++) tick();
    repeat (2) tick();
  endtask

  task automatic checkStream(input string tag, input int n,
                             input int eu[4], input int es[4], input int eb[4]);
    checkOutput({tag, "_count_u"}, q_u.size(), n);
    checkOutput({tag, "_count_s"}, q_s.size(), n);
    checkOutput({tag, "_count_b"}, q_b.size(), n);
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_u%0d", tag, i), (i < q_u.size()) ? q_u[i] : -1, eu[i]);
      checkOutput($sformatf("%s_s%0d", tag, i), (i < q_s.size()) ? q_s[i] : -1, es[i]);
      checkOutput($sformatf("%s_b%0d", tag, i), (i < q_b.size()) ? q_b[i] : -1, eb[i]);
    end
    q_u.delete();
    q_s.delete();
    q_b.delete();
  endtask

  initial begin
    int st;
    int total;
    int idx;
    int bad;
    int snap;
    logic fire;
    logic [IW-1:0] bp_words [4];

    ap_rst        = 1'b1;
    thresh_tdata  = '0;
    thresh_tvalid = 1'b0;
    acc_tdata     = '0;
    acc_tvalid    = 1'b0;
    out_tready    = 1'b1;
    cfg_reload    = 1'b0;

    repeat (2) tick();
    @(negedge ap_clk);
    checkOutput("rst_load_done", load_done_u, 0);
    checkOutput("rst_out_valid", out_valid_u, 0);
    checkOutput("rst_out_data", out_data_u, 0);
    checkOutput("rst_thresh_ready", thresh_rdy_u, 1);
    checkOutput("rst_acc_ready", acc_rdy_u, 0);
    tick();
    ap_rst = 1'b0;

    $display("[TB] basic mapping, thresholds 10 20 30");
    sendThresh(32'd10);
    sendThresh(32'd20);
    @(negedge ap_clk);
    checkOutput("load_done_early", load_done_u, 0);
    tick();
    sendThresh(32'd30);
    @(negedge ap_clk);
    checkOutput("load_done_after_3", load_done_u, 1);
    checkOutput("thresh_ready_run", thresh_rdy_u, 0);
    checkOutput("acc_ready_run", acc_rdy_u, 1);
    tick();

    first_acc = -1;
    first_out = -1;
    total     = 0;
    applyStimulus(32'd5, st);  total += st;
    applyStimulus(32'd10, st); total += st;
    applyStimulus(32'd25, st); total += st;
    applyStimulus(32'd40, st); total += st;
    waitOutputs(4);
    checkOutput("stream_stalls", total, 0);
    checkOutput("latency", first_out - first_acc, 2);
    checkOutput("one_per_cycle", last_out - first_out, 3);
    checkStream("basic", 4, '{0, 1, 2, 3}, '{0, 1, 2, 3}, '{1, 2, 3, 0});

    $display("[TB] backpressure");
    bp_words   = '{32'd15, 32'd25, 32'd35, 32'd5};
    out_tready = 1'b0;
    acc_tvalid = 1'b1;
    idx        = 0;
    for (int c = 0; c < 6; c++) begin
      acc_tdata = bp_words[idx];
      @(negedge ap_clk);
      fire = acc_rdy_u;
      tick();
      if (fire) idx++;
    end
    @(negedge ap_clk);
    checkOutput("bp_accepted", idx, 2);
    checkOutput("bp_acc_ready", acc_rdy_u, 0);
    checkOutput("bp_out_valid", out_valid_u, 1);
    checkOutput("bp_held_data", out_data_u, 1);
    checkOutput("bp_none_emitted", q_u.size(), 0);
    tick();
    out_tready = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      acc_tdata = bp_words[idx];
      @(negedge ap_clk);
      fire = acc_rdy_u;
      tick();
      if (fire) idx++;
    end
    acc_tvalid = 1'b0;
    checkOutput("bp_all_accepted", idx, 4);
    waitOutputs(4);
    checkStream("bp", 4, '{1, 2, 3, 0}, '{1, 2, 3, 0}, '{2, 3, 0, 1});

    $display("[TB] reload with two words in flight");
    out_tready = 1'b0;
    applyStimulus(32'd25, st);
    applyStimulus(32'd40, st);
    cfg_reload = 1'b1;
    tick();
    cfg_reload = 1'b0;
    snap       = acc_count;
    acc_tvalid = 1'b1;
    acc_tdata  = 32'd99;
    bad        = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge ap_clk);
      if (acc_rdy_u) bad++;
      tick();
    end
    out_tready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge ap_clk);
      if (acc_rdy_u) bad++;
      tick();
    end
    acc_tvalid = 1'b0;
    checkOutput("reload_acc_ready_low", bad, 0);
    checkOutput("reload_no_accept", acc_count - snap, 0);
    @(negedge ap_clk);
    checkOutput("reload_in_load", load_done_u, 0);
    checkOutput("reload_thresh_ready", thresh_rdy_u, 1);
    tick();
    checkStream("reload_old", 2, '{2, 3, 0, 0}, '{2, 3, 0, 0}, '{3, 0, 0, 0});
    sendThresh(32'd0);
    sendThresh(32'd0);
    sendThresh(32'd0);
    applyStimulus(32'd7, st);
    applyStimulus(32'd0, st);
    applyStimulus(32'd100, st);
    waitOutputs(3);
    checkStream("reload_new", 3, '{3, 3, 3, 0}, '{3, 3, 3, 0}, '{0, 0, 0, 0});

    $display("[TB] signed versus unsigned compare, thresholds -5 0 5");
    cfg_reload = 1'b1;
    tick();
    cfg_reload = 1'b0;
    sendThresh(32'hFFFF_FFFB);
    cfg_reload = 1'b1;
    tick();
    cfg_reload = 1'b0;
    sendThresh(32'd0);
    sendThresh(32'd5);
    repeat (3) tick();
    @(negedge ap_clk);
    checkOutput("reload_in_load_ignored", load_done_u, 1);
    tick();
    applyStimulus(32'hFFFF_FFF0, st);
    applyStimulus(32'd0, st);
    applyStimulus(32'd7, st);
    waitOutputs(3);
    checkStream("signed", 3, '{2, 1, 2, 0}, '{0, 2, 3, 0}, '{3, 2, 3, 0});

    $display("[TB] reset mid-stream and mid-load");
    out_tready = 1'b0;
    applyStimulus(32'd25, st);
    applyStimulus(32'd40, st);
    ap_rst = 1'b1;
    tick();
    ap_rst     = 1'b0;
    out_tready = 1'b1;
    @(negedge ap_clk);
    checkOutput("rst_stream_out_valid", out_valid_u, 0);
    checkOutput("rst_stream_load_done", load_done_u, 0);
    checkOutput("rst_stream_thresh_ready", thresh_rdy_u, 1);
    tick();
    repeat (3) tick();
    checkOutput("rst_stream_dropped", q_u.size(), 0);
    q_u.delete();
    q_s.delete();
    q_b.delete();

    sendThresh(32'd0);
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    @(negedge ap_clk);
    checkOutput("rst_load_load_done", load_done_u, 0);
    tick();
    sendThresh(32'd0);
    sendThresh(32'd0);
    @(negedge ap_clk);
    checkOutput("partial_load_done", load_done_u, 0);
    checkOutput("partial_acc_ready", acc_rdy_u, 0);
    tick();
    sendThresh(32'd0);
    @(negedge ap_clk);
    checkOutput("full_reload_done", load_done_u, 1);
    tick();
    applyStimulus(32'd5, st);
    waitOutputs(1);
    checkStream("wrap", 1, '{3, 0, 0, 0}, '{3, 0, 0, 0}, '{0, 0, 0, 0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
